// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core control blocks: the operand-forwarding
// select encodings, the MDU scoreboard state encoding and default latencies.
package core_ctrl_pkg;

  // EX operand source selects
  localparam logic [1:0] FWD_REG    = 2'b00;  // register file
  localparam logic [1:0] FWD_EXALU  = 2'b01;  // ALU result of the EX instruction
  localparam logic [1:0] FWD_MEMALU = 2'b10;  // ALU result of the MEM instruction
  localparam logic [1:0] FWD_MEMLD  = 2'b11;  // load data of the MEM instruction

  // MUL/DIV scoreboard states
  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_t;

  // Default configuration
  localparam int DEF_REG_AW     = 5;
  localparam int DEF_MUL_CYCLES = 3;
  localparam int DEF_DIV_CYCLES = 32;
  localparam int DEF_CNT_W      = 6;

endpackage

// File: rtl/hazard_interlock_unit_if.sv
// Pipeline-side view of the hazard/interlock unit: ID/EX/MEM instruction
// attributes in, forwarding selects, interlocks and MDU status out.
interface hazard_interlock_unit_if
  import core_ctrl_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_branch;
  logic              id_mdu_start;
  logic              id_mdu_div;
  logic              id_hilo_rd;
  logic              ex_wreg;
  logic              ex_m2reg;
  logic [REG_AW-1:0] ex_rn;
  logic              mem_wreg;
  logic              mem_m2reg;
  logic [REG_AW-1:0] mem_rn;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              pc_stall;
  logic              id_bubble;
  logic              mdu_busy;
  logic              mdu_done;

  // Pipeline side: supplies instruction attributes, consumes controls
  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_branch,
           id_mdu_start, id_mdu_div, id_hilo_rd,
           ex_wreg, ex_m2reg, ex_rn, mem_wreg, mem_m2reg, mem_rn,
    input  fwd_a, fwd_b, pc_stall, id_bubble, mdu_busy, mdu_done
  );

  // Hazard unit side
  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_branch,
           id_mdu_start, id_mdu_div, id_hilo_rd,
           ex_wreg, ex_m2reg, ex_rn, mem_wreg, mem_m2reg, mem_rn,
    output fwd_a, fwd_b, pc_stall, id_bubble, mdu_busy, mdu_done
  );

endinterface

// File: rtl/mdu_scoreboard.sv
// Tracks an in-flight MULT/DIV: a busy-counter FSM that raises busy while
// HI/LO are being computed and pulses done in the cycle they become valid.
module mdu_scoreboard
  import core_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,   // already qualified by the pipeline stall
  input  logic       div,
  output logic       busy,
  output logic       done,
  output mdu_state_t state
);

  mdu_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] cnt_load;

  // The counter holds the number of BUSY cycles still to come; BUSY is left
  // on the last one (cnt<=1), so done lands exactly L cycles after the start.
  // A latency of 1 loads 0 and still passes through a single BUSY cycle.
  assign cnt_load = div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);

  // State and counter registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= MDU_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      MDU_IDLE: begin
        if (start) begin
          state_next = MDU_BUSY;
          cnt_next   = cnt_load;
        end
      end
      MDU_BUSY: begin
        if (cnt_reg <= CNT_W'(1)) begin
          state_next = MDU_DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      MDU_DONE: begin
        // Back-to-back issue: a new op may start in the done cycle
        if (start) begin
          state_next = MDU_BUSY;
          cnt_next   = cnt_load;
        end else begin
          state_next = MDU_IDLE;
        end
      end
      default: begin
        state_next = MDU_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign busy  = (state_reg == MDU_BUSY);
  assign done  = (state_reg == MDU_DONE);
  assign state = state_reg;

endmodule

// File: rtl/hazard_interlock_unit.sv
// Hazard/forwarding unit for the 5-stage core: EX operand forwarding
// selects, load-use / branch-in-ID / MUL-DIV interlocks.
module hazard_interlock_unit
  import core_ctrl_pkg::*;
#(
  parameter int REG_AW     = DEF_REG_AW,
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input logic                    clk,
  input logic                    resetn,
  hazard_interlock_unit_if.slave bus
);

  logic [REG_AW-1:0] src     [2];
  logic              src_use [2];
  logic [1:0]        fwd_sel [2];
  logic [1:0]        ld_hit;
  logic [1:0]        br_hit;
  logic              ex_fwd_ok, mem_fwd_ok;
  logic              load_use_hz, branch_hz, mdu_hz, stall;
  logic              mdu_start;
  mdu_state_t        mdu_state;

  assign src[0]     = bus.id_rs;
  assign src[1]     = bus.id_rt;
  assign src_use[0] = bus.id_use_rs;
  assign src_use[1] = bus.id_use_rt;

  // Register 0 is hard-wired, so a producer targeting it never matches
  assign ex_fwd_ok  = bus.ex_wreg  && (bus.ex_rn  != '0);
  assign mem_fwd_ok = bus.mem_wreg && (bus.mem_rn != '0);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      // Per-operand forward select: youngest ALU producer wins, a load still
      // in EX cannot forward (it is interlocked instead)
      always_comb begin
        fwd_sel[gi] = FWD_REG;
        if (ex_fwd_ok && !bus.ex_m2reg && (bus.ex_rn == src[gi]))
          fwd_sel[gi] = FWD_EXALU;
        else if (mem_fwd_ok && (bus.mem_rn == src[gi]))
          fwd_sel[gi] = bus.mem_m2reg ? FWD_MEMLD : FWD_MEMALU;
      end

      // Load in EX feeding this operand
      assign ld_hit[gi] = src_use[gi] && ex_fwd_ok && bus.ex_m2reg &&
                          (bus.ex_rn == src[gi]);
      // ID-stage comparator: anything in EX, or a load in MEM, is too late;
      // a MEM ALU result is covered by the comparator's own bypass
      assign br_hit[gi] = src_use[gi] &&
                          ((ex_fwd_ok && (bus.ex_rn == src[gi])) ||
                           (mem_fwd_ok && bus.mem_m2reg && (bus.mem_rn == src[gi])));
    end
  endgenerate

  assign load_use_hz = |ld_hit;
  assign branch_hz   = bus.id_branch && (|br_hit);
  assign mdu_hz      = (bus.id_mdu_start || bus.id_hilo_rd) && (mdu_state == MDU_BUSY);
  assign stall       = resetn && (load_use_hz || branch_hz || mdu_hz);

  // A stalled MDU instruction will re-issue, so it must not start the FSM
  assign mdu_start = bus.id_mdu_start && !stall;

  mdu_scoreboard #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_mdu (
    .clk    (clk),
    .resetn (resetn),
    .start  (mdu_start),
    .div    (bus.id_mdu_div),
    .busy   (bus.mdu_busy),
    .done   (bus.mdu_done),
    .state  (mdu_state)
  );

  assign bus.fwd_a     = resetn ? fwd_sel[0] : FWD_REG;
  assign bus.fwd_b     = resetn ? fwd_sel[1] : FWD_REG;
  assign bus.pc_stall  = stall;
  assign bus.id_bubble = stall;

endmodule

// File: tb/tb_hazard_interlock_unit.sv
// Directed bench for hazard_interlock_unit with default parameters
// (MUL_CYCLES=3, DIV_CYCLES=32).
module tb_hazard_interlock_unit;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic done_seen;

  always #5 clk = ~clk;

  hazard_interlock_unit_if bus ();

  hazard_interlock_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // One comparison, one printed line
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-20s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    chk({tag, "_pcst"}, 8'(bus.pc_stall), 8'(exp));
    chk({tag, "_bubl"}, 8'(bus.id_bubble), 8'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_rs = '0;  bus.id_rt = '0;  bus.id_use_rs = 1'b0;  bus.id_use_rt = 1'b0;
    bus.id_branch = 1'b0;  bus.id_mdu_start = 1'b0;  bus.id_mdu_div = 1'b0;
    bus.id_hilo_rd = 1'b0;
    bus.ex_wreg = 1'b0;  bus.ex_m2reg = 1'b0;  bus.ex_rn = '0;
    bus.mem_wreg = 1'b0;  bus.mem_m2reg = 1'b0;  bus.mem_rn = '0;
  endtask

  initial begin
    clear_inputs();
    resetn = 1'b0;
    tick();
    tick();

    // ---- reset: hazards present but everything suppressed ----
    bus.ex_wreg = 1'b1; bus.ex_m2reg = 1'b1; bus.ex_rn = 5'd9;
    bus.id_rs = 5'd9; bus.id_use_rs = 1'b1;
    bus.mem_wreg = 1'b1; bus.mem_rn = 5'd9;
    #1;
    chk_stall("rst_stall", 1'b0);
    chk("rst_fwd_a", 8'(bus.fwd_a), 8'd0);
    chk("rst_busy", 8'(bus.mdu_busy), 8'd0);
    chk("rst_done", 8'(bus.mdu_done), 8'd0);

    resetn = 1'b1;
    clear_inputs();
    tick();

    // ---- forwarding ----
    bus.ex_wreg = 1'b1; bus.ex_rn = 5'd8; bus.mem_wreg = 1'b1; bus.mem_rn = 5'd8;
    bus.id_rs = 5'd8; bus.id_use_rs = 1'b1; bus.id_rt = 5'd8;
    #1;
    chk("fwd_ex_over_mem_a", 8'(bus.fwd_a), 8'd1);
    chk("fwd_ex_over_mem_b", 8'(bus.fwd_b), 8'd1);
    chk_stall("fwd_ex_nostall", 1'b0);

    bus.ex_rn = 5'd3;
    #1;
    chk("fwd_mem_alu", 8'(bus.fwd_a), 8'd2);
    bus.mem_m2reg = 1'b1;
    #1;
    chk("fwd_mem_load", 8'(bus.fwd_a), 8'd3);
    bus.id_rs = 5'd0; bus.ex_rn = 5'd0; bus.mem_rn = 5'd0; bus.mem_m2reg = 1'b0;
    #1;
    chk("fwd_r0_a", 8'(bus.fwd_a), 8'd0);
    chk("fwd_r0_b", 8'(bus.fwd_b), 8'd0);

    // ---- load-use ----
    clear_inputs();
    bus.ex_wreg = 1'b1; bus.ex_m2reg = 1'b1; bus.ex_rn = 5'd9;
    bus.id_rt = 5'd9; bus.id_use_rt = 1'b1;
    #1;
    chk_stall("ldu_stall", 1'b1);
    chk("ldu_fwd_b_not_ex", 8'(bus.fwd_b), 8'd0);
    bus.id_use_rt = 1'b0;
    #1;
    chk_stall("ldu_unused_rt", 1'b0);
    bus.id_use_rt = 1'b1;
    tick();
    bus.ex_wreg = 1'b0; bus.ex_m2reg = 1'b0; bus.ex_rn = '0;
    bus.mem_wreg = 1'b1; bus.mem_m2reg = 1'b1; bus.mem_rn = 5'd9;
    #1;
    chk("ldu_next_fwd_b", 8'(bus.fwd_b), 8'd3);
    chk_stall("ldu_next", 1'b0);

    // ---- branch in ID ----
    clear_inputs();
    bus.id_branch = 1'b1; bus.id_rs = 5'd4; bus.id_use_rs = 1'b1;
    bus.ex_wreg = 1'b1; bus.ex_rn = 5'd4;
    #1;
    chk_stall("br_ex_alu", 1'b1);
    tick();
    bus.ex_wreg = 1'b0; bus.ex_rn = '0;
    bus.mem_wreg = 1'b1; bus.mem_rn = 5'd4;
    #1;
    chk_stall("br_mem_alu", 1'b0);
    bus.mem_m2reg = 1'b1;
    #1;
    chk_stall("br_mem_load", 1'b1);

    // ---- MDU start blocked by a load-use stall does not start ----
    clear_inputs();
    bus.ex_wreg = 1'b1; bus.ex_m2reg = 1'b1; bus.ex_rn = 5'd5;
    bus.id_rs = 5'd5; bus.id_use_rs = 1'b1; bus.id_mdu_start = 1'b1;
    #1;
    chk_stall("mdu_ldu", 1'b1);
    tick();
    clear_inputs();
    #1;
    chk("mdu_no_start", 8'(bus.mdu_busy), 8'd0);

    // ---- MULT, back-to-back MULT accepted in DONE ----
    bus.id_mdu_start = 1'b1;                      // cycle N
    #1;
    chk_stall("mul_accept", 1'b0);
    tick();
    bus.id_mdu_start = 1'b0; bus.id_hilo_rd = 1'b1; // N+1
    #1;
    chk("mul_busy1", 8'(bus.mdu_busy), 8'd1);
    chk_stall("mul_mflo1", 1'b1);
    tick();                                        // N+2
    chk("mul_busy2", 8'(bus.mdu_busy), 8'd1);
    chk_stall("mul_mflo2", 1'b1);
    tick();                                        // N+3: DONE
    bus.id_hilo_rd = 1'b0; bus.id_mdu_start = 1'b1;
    #1;
    chk("mul_done1", 8'(bus.mdu_done), 8'd1);
    chk("mul_done1_busy", 8'(bus.mdu_busy), 8'd0);
    chk_stall("mul_b2b", 1'b0);
    tick();                                        // N+4
    chk("mul2_busy", 8'(bus.mdu_busy), 8'd1);
    chk_stall("mul_in_busy", 1'b1);
    tick();                                        // N+5
    bus.id_mdu_start = 1'b0;
    #1;
    chk("mul2_busy2", 8'(bus.mdu_busy), 8'd1);
    chk("mul2_nodone", 8'(bus.mdu_done), 8'd0);
    tick();                                        // N+6
    chk("mul_done2", 8'(bus.mdu_done), 8'd1);
    tick();                                        // N+7
    chk("mul_idle_busy", 8'(bus.mdu_busy), 8'd0);
    chk("mul_idle_done", 8'(bus.mdu_done), 8'd0);

    // ---- DIV with dependent MFHI ----
    clear_inputs();
    bus.id_mdu_start = 1'b1; bus.id_mdu_div = 1'b1;
    tick();
    bus.id_mdu_start = 1'b0; bus.id_mdu_div = 1'b0; bus.id_hilo_rd = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      if (k == 5) begin
        bus.ex_wreg = 1'b1; bus.ex_m2reg = 1'b1; bus.ex_rn = 5'd2;
        bus.id_rs = 5'd2; bus.id_use_rs = 1'b1;
      end else begin
        bus.ex_wreg = 1'b0; bus.ex_m2reg = 1'b0; bus.ex_rn = '0;
      end
      #1;
      if (k == 1 || k == 5 || k == 31) begin
        chk($sformatf("div_mfhi_stall%0d", k), 8'(bus.pc_stall), 8'd1);
        chk($sformatf("div_busy%0d", k), 8'(bus.mdu_busy), 8'd1);
        chk($sformatf("div_nodone%0d", k), 8'(bus.mdu_done), 8'd0);
      end
      tick();
    end
    #1;
    chk("div_done", 8'(bus.mdu_done), 8'd1);
    chk_stall("div_done_mfhi", 1'b0);
    tick();
    chk("div_idle_busy", 8'(bus.mdu_busy), 8'd0);
    chk("div_idle_done", 8'(bus.mdu_done), 8'd0);

    // ---- reset mid-divide ----
    clear_inputs();
    bus.id_mdu_start = 1'b1; bus.id_mdu_div = 1'b1;
    tick();
    bus.id_mdu_start = 1'b0; bus.id_mdu_div = 1'b0;
    tick();
    tick();
    chk("rdiv_busy", 8'(bus.mdu_busy), 8'd1);
    resetn = 1'b0;
    bus.id_hilo_rd = 1'b1;
    bus.ex_wreg = 1'b1; bus.ex_rn = 5'd7; bus.id_rs = 5'd7; bus.id_use_rs = 1'b1;
    #1;
    chk_stall("rdiv_rst_stall", 1'b0);
    chk("rdiv_rst_fwd_a", 8'(bus.fwd_a), 8'd0);
    tick();
    chk("rdiv_busy_clr", 8'(bus.mdu_busy), 8'd0);
    chk("rdiv_done_clr", 8'(bus.mdu_done), 8'd0);
    tick();
    resetn = 1'b1;
    clear_inputs();
    done_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.mdu_done === 1'b1 || bus.mdu_busy === 1'b1) done_seen = 1'b1;
    end
    chk("rdiv_abandoned", 8'(done_seen), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
